ram_dp_param: RTL and testbench

// Parametrised simple-dual-port RAM: next generation of the 32x8 single-port RAM.
// - One write port and one independent read port, in the same clock domain.
// - Read latency is configurable, with a read-valid strobe and selectable read/write collision mode.
// - Optional hardware clear of all contents after reset, with a busy flag.
// - Used as the DUT for the RAM verification environment; drv/imon/omon interfaces extend to the new ports.
//

---
 rtl/ram_dp_param.sv | 155 +++++++++++++++
 tb/tb_ram_dp_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_param.sv
// Simple-dual-port RAM with configurable read latency, read-valid strobe,
// selectable same-address collision behaviour and optional post-reset clear.
`timescale 1ns/1ps

module ram_dp_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 5,
    parameter int DEPTH          = 32,
    parameter int RD_LATENCY     = 1,
    parameter int COLLISION_MODE = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic {INIT, RUN} stateT;

    localparam stateT                 LP_RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT : RUN;
    localparam logic [ADDR_WIDTH:0]   LP_DEPTH       = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST        = ADDR_WIDTH'(DEPTH - 1);

    stateT                 r_state;
    stateT                 w_nextState;
    logic                  w_run;
    logic [ADDR_WIDTH-1:0] r_clrCnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_wrInRange;
    logic                  w_rdInRange;
    logic                  w_rdAccept;
    logic                  w_memWe;
    logic [ADDR_WIDTH-1:0] w_memAddr;
    logic [DATA_WIDTH-1:0] w_memData;
    logic [DATA_WIDTH-1:0] w_rdWord;
    logic                  r_err;

    logic                  r_pipeValid [RD_LATENCY];
    logic [DATA_WIDTH-1:0] r_pipeData  [RD_LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= LP_RESET_STATE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (r_state == INIT && r_clrCnt == LP_LAST) begin
            w_nextState = RUN;
        end
    end

    always_comb begin
        w_run = (r_state == RUN);
        busy  = (r_state == INIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clrCnt <= '0;
        end else if (r_state == INIT) begin
            r_clrCnt <= (r_clrCnt == LP_LAST) ? '0 : r_clrCnt + 1'b1;
        end
    end

    assign w_wrInRange = ({1'b0, wr_addr} < LP_DEPTH);
    assign w_rdInRange = ({1'b0, rd_addr} < LP_DEPTH);
    assign w_rdAccept  = w_run && rd_en;

    // The clear sequence owns the write port; rst gates it so nothing lands while held in reset.
    always_comb begin
        w_memWe   = 1'b0;
        w_memAddr = wr_addr;
        w_memData = data_in;
        if (rst) begin
            if (r_state == INIT) begin
                w_memWe   = 1'b1;
                w_memAddr = r_clrCnt;
                w_memData = '0;
            end else if (wr_en && w_wrInRange) begin
                w_memWe = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[w_memAddr] <= w_memData;
        end
    end

    always_comb begin
        w_rdWord = '0;
        if (w_rdInRange) begin
            if (COLLISION_MODE != 0 && wr_en && wr_addr == rd_addr) begin
                w_rdWord = data_in;
            end else begin
                w_rdWord = r_mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_run && ((wr_en && !w_wrInRange) || (rd_en && !w_rdInRange));
        end
    end

    assign err = r_err;

    // Data stages only load on a valid beat so the last stage holds between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipeValid[0] <= 1'b0;
            r_pipeData[0]  <= '0;
        end else begin
            r_pipeValid[0] <= w_rdAccept;
            if (w_rdAccept) begin
                r_pipeData[0] <= w_rdWord;
            end
        end
    end

    for (genvar g = 1; g < RD_LATENCY; g++) begin : g_stage
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_pipeValid[g] <= 1'b0;
                r_pipeData[g]  <= '0;
            end else begin
                r_pipeValid[g] <= r_pipeValid[g-1];
                if (r_pipeValid[g-1]) begin
                    r_pipeData[g] <= r_pipeData[g-1];
                end
            end
        end
    end

    assign rd_valid = r_pipeValid[RD_LATENCY-1];
    assign data_out = r_pipeData[RD_LATENCY-1];

endmodule

// File: tb/tb_ram_dp_param.sv
// Scoreboard bench for ram_dp_param: two instances share stimulus, one with a
// short array / latency 2 / read-old-data, the other full depth / latency 1 / write-through.
`timescale 1ns/1ps

module tb_ram_dp_param;

    typedef struct {
        logic [7:0] data;
        int         due;
    } expT;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wrEn = 1'b0;
    logic [4:0] wrAddr = '0;
    logic [7:0] dataIn = '0;
    logic       rdEn = 1'b0;
    logic [4:0] rdAddr = '0;

    logic [7:0] dataOutA, dataOutB;
    logic       rdValidA, rdValidB;
    logic       busyA, busyB;
    logic       errA, errB;

    int  cycleCnt = 0;
    int  total = 0;
    int  bad = 0;
    expT qA[$];
    expT qB[$];
    int  errQA[$];
    int  errQB[$];

    ram_dp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(24), .RD_LATENCY(2),
                   .COLLISION_MODE(0), .CLEAR_ON_RESET(1)) dutA (
        .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .data_in(dataIn),
        .rd_en(rdEn), .rd_addr(rdAddr), .data_out(dataOutA), .rd_valid(rdValidA),
        .busy(busyA), .err(errA)
    );

    ram_dp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32), .RD_LATENCY(1),
                   .COLLISION_MODE(1), .CLEAR_ON_RESET(1)) dutB (
        .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .data_in(dataIn),
        .rd_en(rdEn), .rd_addr(rdAddr), .data_out(dataOutB), .rd_valid(rdValidB),
        .busy(busyB), .err(errB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    // Expected array contents once the directed writes below have been applied.
    function automatic logic [7:0] expMem(input int a);
        if (a == 3) return 8'h22;
        if (a == 7) return 8'hA5;
        if (a >= 10 && a <= 13) return 8'(8'h30 + a);
        return 8'h00;
    endfunction

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [7:0] wd,
                                 input logic re, input logic [4:0] ra,
                                 input logic [7:0] expA, input logic [7:0] expB);
        expT e;
        wrEn = we; wrAddr = wa; dataIn = wd; rdEn = re; rdAddr = ra;
        if (re) begin
            e.data = expA; e.due = cycleCnt + 2; qA.push_back(e);
            e.data = expB; e.due = cycleCnt + 1; qB.push_back(e);
        end
        if ((we && wa >= 5'd24) || (re && ra >= 5'd24)) errQA.push_back(cycleCnt + 1);
        @(posedge clk); #1;
        wrEn = 1'b0; rdEn = 1'b0;
    endtask

    task automatic checkResetState();
        checkOutput("rstBusyA", 32'(busyA), 32'd1);
        checkOutput("rstBusyB", 32'(busyB), 32'd1);
        checkOutput("rstValidA", 32'(rdValidA), 32'd0);
        checkOutput("rstValidB", 32'(rdValidB), 32'd0);
        checkOutput("rstDataA", 32'(dataOutA), 32'd0);
        checkOutput("rstDataB", 32'(dataOutB), 32'd0);
        checkOutput("rstErrA", 32'(errA), 32'd0);
        checkOutput("rstErrB", 32'(errB), 32'd0);
    endtask

    // Releases reset and counts edges until busy drops; optionally fires requests mid-clear.
    task automatic runInit(input bit inject);
        int  n = 0;
        int  edgesA = 0;
        int  edgesB = 0;
        bit  doneA = 1'b0;
        bit  doneB = 1'b0;
        rst = 1'b1;
        while (!(doneA && doneB) && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (!doneA && !busyA) begin doneA = 1'b1; edgesA = n; end
            if (!doneB && !busyB) begin doneB = 1'b1; edgesB = n; end
            if (inject && n >= 8 && n <= 12) begin
                wrEn = 1'b1; wrAddr = 5'd5; dataIn = 8'hFF; rdEn = 1'b1; rdAddr = 5'd5;
            end else begin
                wrEn = 1'b0; rdEn = 1'b0;
            end
        end
        wrEn = 1'b0; rdEn = 1'b0;
        checkOutput("busyEdgesA", 32'(edgesA), 32'd24);
        checkOutput("busyEdgesB", 32'(edgesB), 32'd32);
    endtask

    always @(negedge clk) begin : monA
        expT e;
        logic expE;
        if (rdValidA) begin
            if (qA.size() == 0) begin
                checkOutput("spuriousValidA", 32'd1, 32'd0);
            end else begin
                e = qA.pop_front();
                checkOutput("dataA", 32'(dataOutA), 32'(e.data));
                checkOutput("latencyA", 32'(cycleCnt), 32'(e.due));
            end
        end else if (qA.size() > 0 && qA[0].due <= cycleCnt) begin
            e = qA.pop_front();
            checkOutput("missingValidA", 32'd0, 32'd1);
        end
        if (errQA.size() > 0 && errQA[0] < cycleCnt) begin
            void'(errQA.pop_front());
            checkOutput("missedErrA", 32'd0, 32'd1);
        end
        expE = (errQA.size() > 0 && errQA[0] == cycleCnt);
        if (expE) void'(errQA.pop_front());
        if (errA || expE) checkOutput("errA", 32'(errA), 32'(expE));
    end

    always @(negedge clk) begin : monB
        expT e;
        if (rdValidB) begin
            if (qB.size() == 0) begin
                checkOutput("spuriousValidB", 32'd1, 32'd0);
            end else begin
                e = qB.pop_front();
                checkOutput("dataB", 32'(dataOutB), 32'(e.data));
                checkOutput("latencyB", 32'(cycleCnt), 32'(e.due));
            end
        end else if (qB.size() > 0 && qB[0].due <= cycleCnt) begin
            e = qB.pop_front();
            checkOutput("missingValidB", 32'd0, 32'd1);
        end
        if (errB) checkOutput("errB", 32'(errB), 32'd0);
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got running want finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkResetState();

        // Clear sequence, with requests fired at addr 5 after it has already been cleared.
        runInit(1'b1);
        for (int a = 0; a < 32; a++) applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'(a), 8'h00, 8'h00);

        // Latency and basic write/read.
        applyStimulus(1'b1, 5'd7, 8'hA5, 1'b0, 5'd0, 8'h00, 8'h00);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd7, 8'hA5, 8'hA5);

        // Same-address collision: old data on A, write-through on B.
        applyStimulus(1'b1, 5'd3, 8'h11, 1'b0, 5'd0, 8'h00, 8'h00);
        applyStimulus(1'b1, 5'd3, 8'h22, 1'b1, 5'd3, 8'h11, 8'h22);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd3, 8'h22, 8'h22);

        // Addresses 25 and 30 are beyond A's 24 words but valid on B.
        applyStimulus(1'b1, 5'd30, 8'h55, 1'b1, 5'd30, 8'h00, 8'h55);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd30, 8'h00, 8'h55);
        applyStimulus(1'b1, 5'd25, 8'h77, 1'b0, 5'd0, 8'h00, 8'h00);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd25, 8'h00, 8'h77);

        for (int a = 10; a <= 13; a++) applyStimulus(1'b1, 5'(a), 8'(8'h30 + a), 1'b0, 5'd0, 8'h00, 8'h00);
        for (int a = 0; a < 24; a++) applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'(a), expMem(a), expMem(a));

        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd7, 8'hA5, 8'hA5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("holdValidA", 32'(rdValidA), 32'd0);
        checkOutput("holdDataA", 32'(dataOutA), 32'hA5);
        checkOutput("holdDataB", 32'(dataOutB), 32'hA5);
        @(posedge clk); #1;

        // Reset in the middle of a read stream.
        for (int a = 0; a < 4; a++) applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'(a), expMem(a), expMem(a));
        rst = 1'b0;
        qA.delete(); qB.delete(); errQA.delete();
        for (int a = 4; a < 10; a++) begin
            rdEn = 1'b1; rdAddr = 5'(a);
            @(posedge clk); #1;
        end
        rdEn = 1'b0;
        checkResetState();
        runInit(1'b0);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd3, 8'h00, 8'h00);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 5'd7, 8'h00, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("drainedA", 32'(qA.size()), 32'd0);
        checkOutput("drainedB", 32'(qB.size()), 32'd0);
        checkOutput("drainedErrA", 32'(errQA.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
